// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - I2S master-transmit serializer (I2S, left- and right-justified)
module i2s_tx_serializer #(
    parameter int DW = 32
) (
    input  logic          pclk,
    input  logic          preset,
    input  logic          en,
    input  logic          sclk_fall_en,
    input  logic [1:0]    word_size,
    input  logic          frame_size,
    input  logic [1:0]    standard,
    input  logic [DW-1:0] fifo_rdata,
    input  logic          fifo_empty,
    output logic          fifo_rd_en,
    output logic          ws_o,
    output logic          sd_o,
    output logic          busy,
    output logic          underrun,
    input  logic          underrun_clr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t      state;
    logic [4:0]  bnext;
    logic        chnext;
    logic [1:0]  ws_q;
    logic [1:0]  std_q;
    logic        fs_q;
    logic [31:0] sreg;
    logic [31:0] samp;

    generate
        if (DW >= 32) begin : g_wide
            assign samp = fifo_rdata[31:0];
        end else begin : g_narrow
            assign samp = {{(32-DW){1'b0}}, fifo_rdata};
        end
    endgenerate

    logic        frame_start;
    logic        proc;
    logic        at_load;
    logic [1:0]  ws_e;
    logic [1:0]  std_e;
    logic        fs_e;
    logic [5:0]  fs_n;
    logic [5:0]  wl_n;
    logic [5:0]  ewl_n;
    logic [5:0]  load_b;
    logic [31:0] aligned;
    logic [31:0] mask;

    // Format fields come straight from the inputs on the frame-start strobe, else from the latch.
    always_comb begin
        frame_start = !chnext && (bnext == 5'd0);
        ws_e        = frame_start ? word_size  : ws_q;
        std_e       = frame_start ? standard   : std_q;
        fs_e        = frame_start ? frame_size : fs_q;
        fs_n        = fs_e ? 6'd32 : 6'd16;
        case (ws_e)
            2'b00:   wl_n = 6'd16;
            2'b01:   wl_n = 6'd24;
            default: wl_n = 6'd32;
        endcase
        ewl_n = (wl_n < fs_n) ? wl_n : fs_n;
        case (std_e)
            2'b01:   load_b = 6'd0;
            2'b10:   load_b = fs_n - ewl_n;
            default: load_b = 6'd1;
        endcase
        proc    = (state == IDLE) ? en : (en || !frame_start);
        at_load = proc && ({1'b0, bnext} == load_b);
        // MSB of the word lands in bit 31; bits past EWL are masked so they shift out as zeros.
        aligned = samp << (6'd32 - wl_n);
        mask    = ~(32'hFFFF_FFFF >> ewl_n);
    end

    assign fifo_rd_en = sclk_fall_en && at_load && !fifo_empty;
    assign busy       = (state != IDLE);

    always_ff @(posedge pclk) begin
        if (preset) begin
            state    <= IDLE;
            bnext    <= 5'd0;
            chnext   <= 1'b0;
            ws_q     <= 2'b00;
            std_q    <= 2'b00;
            fs_q     <= 1'b0;
            sreg     <= 32'h0;
            ws_o     <= 1'b0;
            sd_o     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            if (sclk_fall_en && at_load && fifo_empty) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end

            if (sclk_fall_en && proc) begin
                state <= en ? RUN : STOP;
                ws_o  <= chnext;
                if (frame_start) begin
                    ws_q  <= word_size;
                    std_q <= standard;
                    fs_q  <= frame_size;
                end
                if (at_load) begin
                    sd_o <= !fifo_empty && aligned[31];
                    sreg <= fifo_empty ? 32'h0 : ((aligned & mask) << 1);
                end else begin
                    sd_o <= sreg[31];
                    sreg <= sreg << 1;
                end
                if ({1'b0, bnext} == (fs_n - 6'd1)) begin
                    bnext  <= 5'd0;
                    chnext <= !chnext;
                end else begin
                    bnext <= bnext + 5'd1;
                end
            end else if (sclk_fall_en) begin
                // Stopping at a left b=0: a pending I2S LSB still goes out on this strobe.
                state  <= IDLE;
                ws_o   <= 1'b0;
                sd_o   <= sreg[31];
                sreg   <= 32'h0;
                bnext  <= 5'd0;
                chnext <= 1'b0;
            end else if (state == RUN && !en) begin
                state <= STOP;
            end else if (state == STOP && en) begin
                state <= RUN;
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - self-checking bench for i2s_tx_serializer
module tb_i2s_tx_serializer;

    logic        pclk = 1'b0;
    logic        preset;
    logic        en;
    logic        sclk_fall_en;
    logic [1:0]  word_size;
    logic        frame_size;
    logic [1:0]  standard;
    logic [31:0] fifo_rdata;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic        ws_o;
    logic        sd_o;
    logic        busy;
    logic        underrun;
    logic        underrun_clr;

    always #5 pclk = ~pclk;

    i2s_tx_serializer #(.DW(32)) dut (
        .pclk         (pclk),
        .preset       (preset),
        .en           (en),
        .sclk_fall_en (sclk_fall_en),
        .word_size    (word_size),
        .frame_size   (frame_size),
        .standard     (standard),
        .fifo_rdata   (fifo_rdata),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .ws_o         (ws_o),
        .sd_o         (sd_o),
        .busy         (busy),
        .underrun     (underrun),
        .underrun_clr (underrun_clr)
    );

    typedef struct {
        logic [1:0]  std;
        logic [1:0]  wsz;
        logic        fs;
        int          nsamp;
        logic [31:0] s0;
        logic [31:0] s1;
        logic [31:0] slot0;
        logic [31:0] slot1;
        logic        tail;
        int          npop;
        logic        ur;
    } vec_t;

    vec_t        tbl[6];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] fq[$];
    logic [31:0] samp[0:3];
    logic        got_sd[0:128];
    logic        got_ws[0:128];
    logic        exp_sd[0:128];
    logic        exp_ws[0:128];
    int          pops;
    int          busy_drops;
    int          len;
    int          cur_fs;
    logic        end_busy;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input logic stb);
        logic pop;
        sclk_fall_en = stb;
        fifo_empty   = (fq.size() == 0);
        fifo_rdata   = fifo_empty ? 32'h0 : fq[0];
        #1;
        pop = fifo_rd_en;
        @(posedge pclk);
        #1;
        if (pop) begin
            pops++;
            if (fq.size() != 0) void'(fq.pop_front());
        end
        sclk_fall_en = 1'b0;
    endtask

    // Reference: every slot's word is dropped at its absolute bit position in one flat stream.
    task automatic run_stream(input logic [1:0] std, input logic [1:0] wsz, input logic fs,
                              input int nfr, input int nsamp, input int drop_at);
        int wl, ewl, off;
        cur_fs = fs ? 32 : 16;
        wl     = (wsz == 2'd0) ? 16 : (wsz == 2'd1) ? 24 : 32;
        ewl    = (wl < cur_fs) ? wl : cur_fs;
        off    = (std == 2'd1) ? 0 : (std == 2'd2) ? cur_fs - ewl : 1;
        len    = 2 * nfr * cur_fs;
        for (int p = 0; p <= len; p++) begin
            exp_sd[p] = 1'b0;
            exp_ws[p] = (p < len) ? 1'((p / cur_fs) % 2) : 1'b0;
        end
        for (int s = 0; s < 2 * nfr; s++)
            if (s < nsamp)
                for (int k = 0; k < ewl; k++) exp_sd[s * cur_fs + off + k] = samp[s][wl - 1 - k];
        fq.delete();
        for (int s = 0; s < nsamp; s++) fq.push_back(samp[s]);
        standard = std; word_size = wsz; frame_size = fs;
        pops = 0; busy_drops = 0; en = 1'b1;
        for (int p = 0; p <= len; p++) begin
            if (p == len || p == drop_at) en = 1'b0;
            tick(1'b1);
            got_sd[p] = sd_o;
            got_ws[p] = ws_o;
            if (p < len && !busy) busy_drops++;
            repeat ($urandom_range(1, 2)) tick(1'b0);
        end
        end_busy = busy;
    endtask

    task automatic check_stream(input string tag, input int nsamp, input int nslots);
        int bad_sd, bad_ws;
        bad_sd = 0; bad_ws = 0;
        for (int p = 0; p <= len; p++) begin
            if (got_sd[p] !== exp_sd[p]) bad_sd++;
            if (got_ws[p] !== exp_ws[p]) bad_ws++;
        end
        check($sformatf("%s sd_errs", tag), bad_sd, 0);
        check($sformatf("%s ws_errs", tag), bad_ws, 0);
        check($sformatf("%s pops", tag), pops, nsamp);
        check($sformatf("%s underrun", tag), 32'(underrun), 32'(nsamp < nslots));
        check($sformatf("%s busy_end", tag), 32'(end_busy), 0);
        underrun_clr = 1'b1;
        tick(1'b0);
        underrun_clr = 1'b0;
        if (nsamp < nslots) check($sformatf("%s underrun_clr", tag), 32'(underrun), 0);
    endtask

    function automatic logic [31:0] slot_word(input int s);
        logic [31:0] w;
        w = 32'h0;
        for (int b = 0; b < cur_fs; b++) w = {w[30:0], got_sd[s * cur_fs + b]};
        return w;
    endfunction

    initial begin
        tbl[0] = '{2'd1, 2'd0, 1'b0, 2, 32'h0000A5C3, 32'h00001234, 32'h0000A5C3, 32'h00001234, 1'b0, 2, 1'b0};
        tbl[1] = '{2'd0, 2'd0, 1'b1, 2, 32'h00008001, 32'h00008001, 32'h40008000, 32'h40008000, 1'b0, 2, 1'b0};
        tbl[2] = '{2'd2, 2'd1, 1'b1, 2, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF, 1'b0, 2, 1'b0};
        tbl[3] = '{2'd0, 2'd2, 1'b1, 1, 32'h80000001, 32'h0,        32'h40000000, 32'h80000000, 1'b0, 1, 1'b1};
        tbl[4] = '{2'd3, 2'd3, 1'b0, 2, 32'hF0F01234, 32'hFFFF0000, 32'h00007878, 32'h00007FFF, 1'b1, 2, 1'b0};
        tbl[5] = '{2'd1, 2'd1, 1'b0, 2, 32'h00ABCDEF, 32'h00123456, 32'h0000ABCD, 32'h00001234, 1'b0, 2, 1'b0};

        preset = 1'b1; en = 1'b0; sclk_fall_en = 1'b0; word_size = 2'd0; frame_size = 1'b0;
        standard = 2'd0; fifo_rdata = 32'h0; fifo_empty = 1'b1; underrun_clr = 1'b0;
        repeat (3) tick(1'b1);
        preset = 1'b0;
        tick(1'b0);
        check("rst ws_o", 32'(ws_o), 0);
        check("rst sd_o", 32'(sd_o), 0);
        check("rst busy", 32'(busy), 0);
        check("rst underrun", 32'(underrun), 0);
        check("rst fifo_rd_en", 32'(fifo_rd_en), 0);

        for (int v = 0; v < 6; v++) begin
            samp[0] = tbl[v].s0; samp[1] = tbl[v].s1;
            run_stream(tbl[v].std, tbl[v].wsz, tbl[v].fs, 1, tbl[v].nsamp, 1000);
            check($sformatf("vec%0d slot0", v), slot_word(0), tbl[v].slot0);
            check($sformatf("vec%0d slot1", v), slot_word(1), tbl[v].slot1);
            check($sformatf("vec%0d tail", v), 32'(got_sd[len]), 32'(tbl[v].tail));
            check($sformatf("vec%0d pops", v), pops, tbl[v].npop);
            check_stream($sformatf("vec%0d", v), tbl[v].nsamp, 2);
        end

        // en falls after left b=5; the frame still completes and stops at the next left b=0
        samp[0] = 32'h0000BEEF; samp[1] = 32'h00000F0F;
        run_stream(2'd1, 2'd0, 1'b0, 1, 2, 6);
        check("drop busy_held", busy_drops, 0);
        check_stream("drop", 2, 2);

        // preset mid-slot aborts at once and nothing pops while disabled
        fq.delete();
        for (int i = 0; i < 4; i++) fq.push_back(32'h0000FFFF);
        standard = 2'd1; word_size = 2'd0; frame_size = 1'b0; en = 1'b1; pops = 0;
        for (int p = 0; p < 20; p++) begin
            tick(1'b1);
            tick(1'b0);
        end
        check("pre_rst ws_o", 32'(ws_o), 1);
        preset = 1'b1; en = 1'b0;
        tick(1'b0);
        preset = 1'b0;
        check("mid_rst ws_o", 32'(ws_o), 0);
        check("mid_rst sd_o", 32'(sd_o), 0);
        check("mid_rst busy", 32'(busy), 0);
        pops = 0;
        for (int p = 0; p < 6; p++) begin
            tick(1'b1);
            tick(1'b0);
        end
        check("mid_rst no_pop", pops, 0);
        check("mid_rst idle sd", 32'(sd_o), 0);
        fq.delete();

        for (int r = 0; r < 24; r++) begin
            logic [1:0] std, wsz;
            logic       fs;
            int         nfr, nsamp, drop;
            std   = 2'($urandom_range(0, 3));
            wsz   = 2'($urandom_range(0, 3));
            fs    = 1'($urandom_range(0, 1));
            nfr   = $urandom_range(1, 2);
            nsamp = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 2 * nfr) : 2 * nfr;
            drop  = (nfr == 1) ? $urandom_range(1, 32) : 1000;
            for (int i = 0; i < 4; i++) samp[i] = $urandom;
            run_stream(std, wsz, fs, nfr, nsamp, drop);
            check_stream($sformatf("rnd%0d", r), nsamp, 2 * nfr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
